alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WORD_LEN, default 32, meaning operand/result width (power of two, >= 8).
REQ-002 SHALL have parameter EXE_CMD_LEN, default 4, meaning width of the execute-command field.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port val1  input  WORD_LEN  first operand (dividend, multiplicand).
REQ-006 SHALL have port val2  input  WORD_LEN  second operand (divisor, multiplier, shift amount).
REQ-007 SHALL have port EXE_CMD  input  EXE_CMD_LEN  operation select.
REQ-008 SHALL have port start  input  1  one-cycle request to begin MULTU/DIVU.
REQ-009 SHALL have port aluOut  output  WORD_LEN  single-cycle result, combinational.
REQ-010 SHALL have port hi  output  WORD_LEN  HI register (product upper half / remainder).
REQ-011 SHALL have port lo  output  WORD_LEN  LO register (product lower half / quotient).
REQ-012 SHALL have port busy  output  1  iterative operation in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse; hi/lo newly valid.

Function
REQ-014 SHALL compute aluOut combinationally for ADD, SUB, AND, OR, NOR, XOR (modulo 2^WORD_LEN, no overflow flag).
REQ-015 SHALL implement SLL/SRL as logical and SRA as arithmetic shifts of val1 by val2[log2(WORD_LEN)-1:0]; upper val2 bits ignored.
REQ-016 SHALL drive aluOut = hi for MFHI, lo for MFLO, and 0 for MULTU, DIVU and undefined codes.
REQ-017 SHALL use FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-018 SHALL, in IDLE or DONE with start=1 and EXE_CMD=MULTU (DIVU), capture val1/val2 and enter MUL (DIV); start with any other EXE_CMD is ignored.
REQ-019 SHALL ignore start while in MUL or DIV; operands are not re-sampled.
REQ-020 SHALL perform one unsigned shift-add (MUL) or restoring shift-subtract (DIV) step per cycle for exactly WORD_LEN cycles, then enter DONE.
REQ-021 SHALL hold busy=1 exactly while in MUL or DIV (WORD_LEN cycles), and done=1 exactly while in DONE (one cycle).
REQ-022 SHALL update hi/lo only on the MUL/DIV-to-DONE transition: MULTU -> {hi,lo} = val1*val2 (2*WORD_LEN bits); DIVU -> lo = quotient, hi = remainder.
REQ-023 SHALL, for DIVU with val2=0, produce lo = all ones, hi = val1, with unchanged latency.
REQ-024 SHALL leave DONE for IDLE after one cycle unless a new start is accepted in that cycle (back-to-back).
REQ-025 SHALL keep hi/lo stable across single-cycle ops and until the next completion.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, set state IDLE, hi=0, lo=0, busy=0, done=0, clear iteration counter and operand registers.
REQ-027 SHALL abort any in-flight MUL/DIV on reset with no hi/lo update and no done pulse; rst has priority over start.

Structure
REQ-028 SHALL take all EXE_CMD codes (existing ADD..SRL plus new MULTU, DIVU, MFHI, MFLO) and EXE_CMD_LEN from the shared defines file; FSM state encodings stay local.
REQ-029 SHALL contain one sub-module, muldiv_iter, holding FSM, counter and datapath; alu_muldiv holds the combinational ALU and the MFHI/MFLO mux.

Verification
REQ-030 SHALL check, WORD_LEN=32: SRA val1=0x80000010, val2=0x24 -> aluOut=0xF8000001; SRL same -> 0x08000001.
REQ-031 SHALL check MULTU 0xFFFFFFFF*0xFFFFFFFF with start pulse -> busy 32 cycles, done one cycle later, hi=0xFFFFFFFE, lo=0x00000001.
REQ-032 SHALL check DIVU 100/7 -> lo=14, hi=2; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, same latency.
REQ-033 SHALL check start asserted during cycle 10 of busy -> ignored, result of first op unchanged; start in DONE cycle -> new op begins with no idle gap.
REQ-034 SHALL check rst at busy cycle 16 -> next cycle busy=0, done never pulses, hi=lo=0.
REQ-035 SHALL check WORD_LEN=8: MULTU 200*3 -> hi=0x02, lo=0x58 after 8 busy cycles.

Source files
------------

// File: rtl/alu_muldiv_pkg.sv
// rtl/alu_muldiv_pkg.sv - shared execute-command codes for the ALU and mul/div unit
package alu_muldiv_pkg;

   // Width of the execute-command field shared by decode and execute.
   localparam int CMD_LEN = 4;

   // Single-cycle ALU operations.
   localparam logic [CMD_LEN-1:0] CMD_ADD   = 4'd0;
   localparam logic [CMD_LEN-1:0] CMD_SUB   = 4'd2;
   localparam logic [CMD_LEN-1:0] CMD_AND   = 4'd4;
   localparam logic [CMD_LEN-1:0] CMD_OR    = 4'd5;
   localparam logic [CMD_LEN-1:0] CMD_NOR   = 4'd6;
   localparam logic [CMD_LEN-1:0] CMD_XOR   = 4'd7;
   localparam logic [CMD_LEN-1:0] CMD_SLL   = 4'd8;
   localparam logic [CMD_LEN-1:0] CMD_SRA   = 4'd9;
   localparam logic [CMD_LEN-1:0] CMD_SRL   = 4'd10;

   // Iterative operations and HI/LO moves.
   localparam logic [CMD_LEN-1:0] CMD_MULTU = 4'd11;
   localparam logic [CMD_LEN-1:0] CMD_DIVU  = 4'd12;
   localparam logic [CMD_LEN-1:0] CMD_MFHI  = 4'd13;
   localparam logic [CMD_LEN-1:0] CMD_MFLO  = 4'd14;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative unsigned shift-add multiplier / restoring divider with HI/LO
module muldiv_iter #(
   parameter int WORD_LEN = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_mul_i,
   input  logic                start_div_i,
   input  logic [WORD_LEN-1:0] val1_i,
   input  logic [WORD_LEN-1:0] val2_i,
   output logic [WORD_LEN-1:0] hi_o,
   output logic [WORD_LEN-1:0] lo_o,
   output logic                busy_o,
   output logic                done_o
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   localparam int CNT_W = $clog2(WORD_LEN);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WORD_LEN - 1);

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   // work_q is {hi-half, lo-half}: product accumulator / multiplier for MUL,
   // partial remainder / dividend-becoming-quotient for DIV.
   logic [2*WORD_LEN-1:0]   work_q, work_d;
   // Multiplicand for MUL, divisor for DIV.
   logic [WORD_LEN-1:0]     opnd_q, opnd_d;
   logic [WORD_LEN-1:0]     hi_q, hi_d;
   logic [WORD_LEN-1:0]     lo_q, lo_d;

   logic [WORD_LEN:0]       mul_sum;
   logic [2*WORD_LEN-1:0]   mul_next;
   logic [WORD_LEN:0]       div_shift;
   logic [WORD_LEN:0]       div_trial;
   logic                    div_ok;
   logic [2*WORD_LEN-1:0]   div_next;
   logic                    last;

   // One datapath step: conditional add then shift right (MUL); shift left,
   // trial subtract, keep or restore (DIV). A zero divisor always "fits",
   // which naturally yields all-ones quotient and remainder = dividend.
   always_comb begin
      mul_sum   = {1'b0, work_q[2*WORD_LEN-1:WORD_LEN]} + {1'b0, opnd_q};
      mul_next  = work_q[0] ? {mul_sum, work_q[WORD_LEN-1:1]}
                            : {1'b0, work_q[2*WORD_LEN-1:1]};
      div_shift = work_q[2*WORD_LEN-1:WORD_LEN-1];
      div_trial = div_shift - {1'b0, opnd_q};
      div_ok    = ~div_trial[WORD_LEN];
      div_next  = {(div_ok ? div_trial[WORD_LEN-1:0] : div_shift[WORD_LEN-1:0]),
                   work_q[WORD_LEN-2:0], div_ok};
      last      = (cnt_q == LAST_STEP);
   end

   // Next-state logic: accept new ops from IDLE/DONE, step for WORD_LEN cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      opnd_d  = opnd_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start_mul_i) begin
               state_d = MUL;
               opnd_d  = val1_i;
               work_d  = {{WORD_LEN{1'b0}}, val2_i};
               cnt_d   = '0;
            end else if (start_div_i) begin
               state_d = DIV;
               opnd_d  = val2_i;
               work_d  = {{WORD_LEN{1'b0}}, val1_i};
               cnt_d   = '0;
            end
         end
         MUL: begin
            work_d = mul_next;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
               state_d = DONE;
               hi_d    = mul_next[2*WORD_LEN-1:WORD_LEN];
               lo_d    = mul_next[WORD_LEN-1:0];
            end
         end
         DIV: begin
            work_d = div_next;
            cnt_d  = cnt_q + 1'b1;
            if (last) begin
               state_d = DONE;
               hi_d    = div_next[2*WORD_LEN-1:WORD_LEN];
               lo_d    = div_next[WORD_LEN-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any in-flight operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
         opnd_q  <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         opnd_q  <= opnd_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = (state_q == MUL) || (state_q == DIV);
   assign done_o = (state_q == DONE);

endmodule

// File: rtl/alu_muldiv.sv
// rtl/alu_muldiv.sv - combinational ALU with HI/LO moves around the iterative mul/div unit
module alu_muldiv
   import alu_muldiv_pkg::*;
#(
   parameter int WORD_LEN    = 32,
   parameter int EXE_CMD_LEN = CMD_LEN
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WORD_LEN-1:0]    val1,
   input  logic [WORD_LEN-1:0]    val2,
   input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
   input  logic                   start,
   output logic [WORD_LEN-1:0]    aluOut,
   output logic [WORD_LEN-1:0]    hi,
   output logic [WORD_LEN-1:0]    lo,
   output logic                   busy,
   output logic                   done
);

   localparam int SHW = $clog2(WORD_LEN);

   logic [SHW-1:0] shamt;
   logic           start_mul;
   logic           start_div;

   assign shamt     = val2[SHW-1:0];
   assign start_mul = start && (EXE_CMD == CMD_MULTU);
   assign start_div = start && (EXE_CMD == CMD_DIVU);

   muldiv_iter #(
      .WORD_LEN (WORD_LEN)
   ) u_iter (
      .clk         (clk),
      .rst         (rst),
      .start_mul_i (start_mul),
      .start_div_i (start_div),
      .val1_i      (val1),
      .val2_i      (val2),
      .hi_o        (hi),
      .lo_o        (lo),
      .busy_o      (busy),
      .done_o      (done)
   );

   // Single-cycle result select; iterative ops and unknown codes read as zero.
   always_comb begin
      aluOut = '0;
      case (EXE_CMD)
         CMD_ADD:  aluOut = val1 + val2;
         CMD_SUB:  aluOut = val1 - val2;
         CMD_AND:  aluOut = val1 & val2;
         CMD_OR:   aluOut = val1 | val2;
         CMD_NOR:  aluOut = ~(val1 | val2);
         CMD_XOR:  aluOut = val1 ^ val2;
         CMD_SLL:  aluOut = val1 << shamt;
         CMD_SRL:  aluOut = val1 >> shamt;
         CMD_SRA:  aluOut = WORD_LEN'($signed(val1) >>> shamt);
         CMD_MFHI: aluOut = hi;
         CMD_MFLO: aluOut = lo;
         default:  aluOut = '0;
      endcase
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb/tb_alu_muldiv.sv - directed self-checking bench for alu_muldiv
module tb_alu_muldiv;
   import alu_muldiv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] val1 = '0, val2 = '0;
   logic [3:0]  cmd = '0;
   logic        start = 1'b0;
   logic [31:0] alu_out, hi, lo;
   logic        busy, done;

   logic [7:0]  val1_8 = '0, val2_8 = '0;
   logic [3:0]  cmd8 = '0;
   logic        start8 = 1'b0;
   logic [7:0]  alu_out8, hi8, lo8;
   logic        busy8, done8;

   int errors = 0;
   int checks = 0;
   int cyc;
   int pulses;

   always #5 clk = ~clk;

   alu_muldiv #(.WORD_LEN(32), .EXE_CMD_LEN(4)) dut (
      .clk(clk), .rst(rst), .val1(val1), .val2(val2), .EXE_CMD(cmd), .start(start),
      .aluOut(alu_out), .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   alu_muldiv #(.WORD_LEN(8), .EXE_CMD_LEN(4)) dut8 (
      .clk(clk), .rst(rst), .val1(val1_8), .val2(val2_8), .EXE_CMD(cmd8), .start(start8),
      .aluOut(alu_out8), .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
      cmd = c; val1 = a; val2 = b;
      #1;
      check(tag, alu_out, exp);
   endtask

   // Issue a MULTU/DIVU at a negedge, scramble operands afterwards, and return
   // the number of busy cycles; ends on the negedge where busy has dropped.
   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      cmd = c; val1 = a; val2 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; val1 = 32'hDEAD_BEEF; val2 = 32'h1234_5678;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_hi", hi, 32'h0);
      check("reset_lo", lo, 32'h0);
      check("reset_busy", {31'b0, busy}, 32'h0);
      check("reset_done", {31'b0, done}, 32'h0);
      rst = 1'b0;

      alu(CMD_ADD, 32'd5, 32'd7, 32'd12, "add");
      alu(CMD_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, "sub_wrap");
      alu(CMD_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, "and");
      alu(CMD_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, "or");
      alu(CMD_NOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, "nor");
      alu(CMD_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, "xor");
      alu(CMD_SRA, 32'h8000_0010, 32'h24, 32'hF800_0001, "sra");
      alu(CMD_SRL, 32'h8000_0010, 32'h24, 32'h0800_0001, "srl");
      alu(CMD_SLL, 32'h8000_0010, 32'h24, 32'h0000_0100, "sll");
      alu(4'd15, 32'h1234, 32'h5678, 32'h0, "undef_code");
      alu(CMD_MULTU, 32'h1234, 32'h5678, 32'h0, "multu_aluout");
      @(negedge clk);

      run_op(CMD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
      check("mul_busy_cycles", cyc, 32);
      check("mul_done", {31'b0, done}, 32'h1);
      check("mul_hi", hi, 32'hFFFF_FFFE);
      check("mul_lo", lo, 32'h0000_0001);
      @(negedge clk);
      check("mul_done_one_cycle", {31'b0, done}, 32'h0);
      check("mul_hi_stable", hi, 32'hFFFF_FFFE);

      run_op(CMD_DIVU, 32'd100, 32'd7, cyc);
      check("div_busy_cycles", cyc, 32);
      check("div_lo", lo, 32'd14);
      check("div_hi", hi, 32'd2);
      alu(CMD_MFHI, 32'h0, 32'h0, 32'd2, "mfhi");
      alu(CMD_MFLO, 32'h0, 32'h0, 32'd14, "mflo");
      @(negedge clk);

      run_op(CMD_DIVU, 32'd5, 32'd0, cyc);
      check("div0_busy_cycles", cyc, 32);
      check("div0_lo", lo, 32'hFFFF_FFFF);
      check("div0_hi", hi, 32'd5);
      @(negedge clk);

      // Start during busy cycle 10 must be ignored.
      cmd = CMD_MULTU; val1 = 32'd3; val2 = 32'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         if (cyc == 10) begin
            start = 1'b1; cmd = CMD_DIVU; val1 = 32'd100; val2 = 32'd7;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("ign_busy_cycles", cyc, 32);
      check("ign_lo", lo, 32'd12);
      check("ign_hi", hi, 32'd0);
      @(negedge clk);
      check("ign_no_second_op", {31'b0, busy}, 32'h0);

      // Back-to-back: new start accepted in the DONE cycle.
      run_op(CMD_MULTU, 32'd6, 32'd7, cyc);
      check("b2b_first_lo", lo, 32'd42);
      check("b2b_first_done", {31'b0, done}, 32'h1);
      cmd = CMD_DIVU; val1 = 32'd100; val2 = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_no_gap_busy", {31'b0, busy}, 32'h1);
      check("b2b_no_gap_done", {31'b0, done}, 32'h0);
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      check("b2b_busy_cycles", cyc, 32);
      check("b2b_lo", lo, 32'd14);
      check("b2b_hi", hi, 32'd2);
      @(negedge clk);

      // Reset at busy cycle 16 aborts the operation.
      cmd = CMD_MULTU; val1 = 32'hFFFF_FFFF; val2 = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 16) begin
         cyc++;
         if (cyc < 16) @(negedge clk);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("rst_no_done_pulse", pulses, 0);

      // 8-bit instance multiply.
      cmd8 = CMD_MULTU; val1_8 = 8'd200; val2_8 = 8'd3; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      cyc = 0;
      while (busy8 && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      check("w8_busy_cycles", cyc, 8);
      check("w8_done", {31'b0, done8}, 32'h1);
      check("w8_hi", {24'b0, hi8}, 32'h02);
      check("w8_lo", {24'b0, lo8}, 32'h58);
      cmd8 = CMD_MFLO;
      #1;
      check("w8_mflo", {24'b0, alu_out8}, 32'h58);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
